storage_sequencer: RTL and testbench

//  Sequences every access to the storage block (tank/projectile registers + wall RAM); sole driver of its mode/wren/address/data.

---
 rtl/storage_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_storage_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/storage_sequencer.sv
// Sequences all storage accesses: arbitrates tank moves, wall writes and
// self-scheduled projectile steps, one op in flight at a time.
module storage_sequencer #(
    parameter logic [7:0] PROJ_PERIOD = 8'd4,
    parameter logic [3:0] PROJ_RANGE  = 4'd15,
    parameter logic [1:0] SETTLE      = 2'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       t1_req,
    input  logic [7:0] t1_dir,
    input  logic       t2_req,
    input  logic [7:0] t2_dir,
    input  logic       t1_fire,
    input  logic       t2_fire,
    input  logic       wall_req,
    input  logic [7:0] wall_addr,
    input  logic [7:0] wall_data,
    output logic       t1_ack,
    output logic       t2_ack,
    output logic       wall_ack,
    output logic       busy,
    output logic       t1_proj_on,
    output logic       t2_proj_on,
    output logic [3:0] mode,
    output logic       wren,
    output logic [7:0] address,
    output logic [7:0] data
);

    typedef enum logic [1:0] {StIdle, StIssue, StSettle, StDone} state_t;
    typedef enum logic [2:0] {SrcT1, SrcT2, SrcWall, SrcP1, SrcP2} src_t;

    state_t          state;
    src_t            src;
    logic [1:0]      settle_cnt;
    logic [7:0]      tick_cnt;
    logic            rr_t2;
    logic [1:0][7:0] last_dir;
    logic [1:0]      p_on, p_due;
    logic [1:0][7:0] p_dir;
    logic [1:0][3:0] p_rem;

    logic            gnt;
    src_t            g_src;
    logic [3:0]      g_mode;
    logic [7:0]      g_addr, g_data;
    logic            wrap;
    logic [1:0]      fire, step_done, on_n, due_n;
    logic [1:0][7:0] dir_n;
    logic [1:0][3:0] rem_n;
    logic            t1_ok, t2_ok, wall_ok;

    assign t1_proj_on = p_on[0];
    assign t2_proj_on = p_on[1];
    assign fire       = {t2_fire, t1_fire};
    assign wrap       = tick && (tick_cnt == PROJ_PERIOD - 8'd1);
    // A requester still sees its ack this cycle; don't regrant it before it can drop req.
    assign t1_ok      = t1_req & ~t1_ack;
    assign t2_ok      = t2_req & ~t2_ack;
    assign wall_ok    = wall_req & ~wall_ack;

    always_comb begin
        gnt    = 1'b1;
        g_src  = SrcT1;
        g_mode = 4'b0000;
        g_addr = 8'h00;
        g_data = 8'h00;
        if (p_due[0]) begin
            g_src  = SrcP1;
            g_mode = 4'b0011;
            g_data = p_dir[0];
        end else if (p_due[1]) begin
            g_src  = SrcP2;
            g_mode = 4'b0111;
            g_data = p_dir[1];
        end else if (wall_ok) begin
            g_src  = SrcWall;
            g_addr = wall_addr;
            g_data = wall_data;
        end else if (t1_ok && (!t2_ok || rr_t2)) begin
            g_src  = SrcT1;
            g_mode = 4'b0001;
            g_data = t1_dir;
        end else if (t2_ok) begin
            g_src  = SrcT2;
            g_mode = 4'b0101;
            g_data = t2_dir;
        end else begin
            gnt = 1'b0;
        end
    end

    always_comb begin
        step_done[0] = (state == StDone) && (src == SrcP1);
        step_done[1] = (state == StDone) && (src == SrcP2);
        for (int i = 0; i < 2; i++) begin
            on_n[i]  = p_on[i];
            due_n[i] = p_due[i];
            dir_n[i] = p_dir[i];
            rem_n[i] = p_rem[i];
            if (step_done[i]) begin
                due_n[i] = 1'b0;
                rem_n[i] = p_rem[i] - 4'd1;
                if (p_rem[i] == 4'd1) on_n[i] = 1'b0;
            end else if (fire[i] && !p_on[i]) begin
                on_n[i]  = 1'b1;
                dir_n[i] = last_dir[i];
                rem_n[i] = PROJ_RANGE;
            end
            // Only projectiles already active at the wrap get a step due.
            if (wrap && p_on[i] && on_n[i]) due_n[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            src        <= SrcT1;
            settle_cnt <= 2'd0;
            tick_cnt   <= 8'd0;
            rr_t2      <= 1'b0;
            last_dir   <= {8'h00, 8'h01};
            p_on       <= 2'b00;
            p_due      <= 2'b00;
            p_dir      <= '0;
            p_rem      <= '0;
            t1_ack     <= 1'b0;
            t2_ack     <= 1'b0;
            wall_ack   <= 1'b0;
            busy       <= 1'b0;
            mode       <= 4'b0000;
            wren       <= 1'b0;
            address    <= 8'h00;
            data       <= 8'h00;
        end else begin
            t1_ack   <= 1'b0;
            t2_ack   <= 1'b0;
            wall_ack <= 1'b0;
            if (tick) tick_cnt <= wrap ? 8'd0 : tick_cnt + 8'd1;
            p_on  <= on_n;
            p_due <= due_n;
            p_dir <= dir_n;
            p_rem <= rem_n;
            unique case (state)
                StIdle: begin
                    if (gnt) begin
                        state      <= StIssue;
                        src        <= g_src;
                        busy       <= 1'b1;
                        wren       <= 1'b1;
                        mode       <= g_mode;
                        address    <= g_addr;
                        data       <= g_data;
                        settle_cnt <= SETTLE - 2'd1;
                        if (g_src == SrcT1) rr_t2 <= 1'b0;
                        if (g_src == SrcT2) rr_t2 <= 1'b1;
                    end
                end
                StIssue: begin
                    wren  <= 1'b0;
                    state <= StSettle;
                end
                StSettle: begin
                    if (settle_cnt == 2'd0) state <= StDone;
                    else settle_cnt <= settle_cnt - 2'd1;
                end
                StDone: begin
                    state   <= StIdle;
                    busy    <= 1'b0;
                    mode    <= 4'b0000;
                    address <= 8'h00;
                    data    <= 8'h00;
                    if (src == SrcT1) begin
                        t1_ack      <= 1'b1;
                        last_dir[0] <= data;
                    end
                    if (src == SrcT2) begin
                        t2_ack      <= 1'b1;
                        last_dir[1] <= data;
                    end
                    if (src == SrcWall) wall_ack <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_storage_sequencer.sv
// Directed bench for storage_sequencer: arbitration, op timing, projectile
// scheduling and reset abort.
module tb_storage_sequencer;

    logic       clk = 1'b0;
    logic       reset, tick, t1_req, t2_req, t1_fire, t2_fire, wall_req;
    logic [7:0] t1_dir, t2_dir, wall_addr, wall_data;
    logic       t1_ack, t2_ack, wall_ack, busy, t1_proj_on, t2_proj_on, wren;
    logic [3:0] mode;
    logic [7:0] address, data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [3:0] log_mode[128];
    logic [7:0] log_addr[128];
    logic [7:0] log_data[128];
    int         n_wr = 0;

    storage_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick),
        .t1_req(t1_req), .t1_dir(t1_dir), .t2_req(t2_req), .t2_dir(t2_dir),
        .t1_fire(t1_fire), .t2_fire(t2_fire),
        .wall_req(wall_req), .wall_addr(wall_addr), .wall_data(wall_data),
        .t1_ack(t1_ack), .t2_ack(t2_ack), .wall_ack(wall_ack), .busy(busy),
        .t1_proj_on(t1_proj_on), .t2_proj_on(t2_proj_on),
        .mode(mode), .wren(wren), .address(address), .data(data)
    );

    always #5 clk = ~clk;

    // Record every storage write issued.
    always @(posedge clk) begin
        if (wren && n_wr < 128) begin
            log_mode[n_wr] <= mode;
            log_addr[n_wr] <= address;
            log_data[n_wr] <= data;
            n_wr           <= n_wr + 1;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int which, input int limit, input string tag);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            seen = (which == 1) ? t1_ack : (which == 2) ? t2_ack : wall_ack;
        end
        chk(tag, seen, 1);
    endtask

    function automatic int count_steps(input int from);
        int c = 0;
        for (int i = from; i < n_wr; i++) if (log_mode[i] == 4'b0011) c++;
        return c;
    endfunction

    int base, a1, a2, s5;

    initial begin
        reset = 1; tick = 0; t1_req = 0; t2_req = 0; t1_fire = 0; t2_fire = 0;
        wall_req = 0; t1_dir = 0; t2_dir = 0; wall_addr = 0; wall_data = 0;
        step(2);
        reset = 0;
        step();
        chk("rst_mode", mode, 4'h0);
        chk("rst_wren", wren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {t1_ack, t2_ack, wall_ack}, 3'b000);
        chk("rst_proj", {t1_proj_on, t2_proj_on}, 2'b00);
        chk("rst_addr_data", {address, data}, 16'h0000);

        // Single tank1 move
        base = n_wr;
        t1_req = 1; t1_dir = 8'h07;
        step();
        chk("t1_issue_wren", wren, 1);
        chk("t1_issue_mode", mode, 4'b0001);
        chk("t1_issue_data", data, 8'h07);
        chk("t1_issue_busy", busy, 1);
        step(3);
        chk("t1_done_noack", t1_ack, 0);
        step();
        chk("t1_ack_at5", t1_ack, 1);
        chk("t1_ack_idle", {busy, mode}, 5'h00);
        t1_req = 0;
        step();
        chk("t1_ack_pulse", t1_ack, 0);
        step(3);
        chk("t1_one_wren", n_wr - base, 1);

        // Contending tanks: round robin starting with tank2
        base = n_wr; a1 = 0; a2 = 0;
        t1_req = 1; t1_dir = 8'h03; t2_req = 1; t2_dir = 8'h07;
        for (int i = 0; i < 40 && a1 + a2 < 4; i++) begin
            step();
            a1 += int'(t1_ack);
            a2 += int'(t2_ack);
        end
        t1_req = 0; t2_req = 0;
        step(6);
        chk("rr_t1_acks", a1, 2);
        chk("rr_t2_acks", a2, 2);
        chk("rr_ops", n_wr - base, 4);
        chk("rr_order", {log_mode[base], log_mode[base+1], log_mode[base+2], log_mode[base+3]},
            16'h5151);
        chk("rr_data", {log_data[base], log_data[base+1]}, 16'h0703);

        // Wall write beats a tank move
        base = n_wr;
        wall_req = 1; wall_addr = 8'h35; wall_data = 8'h01; t1_req = 1; t1_dir = 8'h00;
        step();
        chk("wall_issue", {wren, mode, address, data}, {1'b1, 4'h0, 8'h35, 8'h01});
        wait_ack(3, 10, "wall_ack_seen");
        wall_req = 0;
        wait_ack(1, 12, "wall_then_t1_ack");
        t1_req = 0;
        step(2);
        chk("wall_then_t1_ops", n_wr - base, 2);
        chk("wall_then_t1_op", {log_mode[base+1], log_addr[base+1], log_data[base+1]},
            {4'h1, 8'h00, 8'h00});

        // Projectile: fire, first step preempts tank2, then runs out after 15 steps
        reset = 1;
        step();
        reset = 0;
        step();
        t1_fire = 1;
        step();
        t1_fire = 0;
        chk("fire_on", {t1_proj_on, t2_proj_on}, 2'b10);
        repeat (4) begin
            tick = 1;
            step();
            tick = 0;
        end
        base = n_wr;
        t2_req = 1; t2_dir = 8'h03;
        step();
        chk("step_issue", {wren, mode, data}, {1'b1, 4'b0011, 8'h01});
        wait_ack(2, 15, "step_then_t2_ack");
        t2_req = 0;
        chk("step_then_t2_op", {log_mode[base+1], log_data[base+1]}, {4'b0101, 8'h03});
        repeat (52) begin
            tick = 1;
            step();
            tick = 0;
            step(7);
        end
        chk("proj_alive_14", t1_proj_on, 1);
        chk("steps_14", count_steps(base), 14);
        repeat (4) begin
            tick = 1;
            step();
            tick = 0;
            step(7);
        end
        chk("proj_off_15", t1_proj_on, 0);
        chk("steps_15", count_steps(base), 15);
        repeat (4) begin
            tick = 1;
            step();
            tick = 0;
            step(7);
        end
        s5 = count_steps(base);
        chk("no_step_after_off", s5, 15);

        // Reset during SETTLE aborts the move
        t2_fire = 1;
        step();
        t2_fire = 0;
        chk("t2_fire_on", t2_proj_on, 1);
        t1_req = 1; t1_dir = 8'h03;
        step(2);
        chk("settle_state", {busy, wren}, 2'b10);
        reset = 1;
        step();
        chk("abort_idle", {busy, wren, mode}, 6'h00);
        chk("abort_proj", {t1_proj_on, t2_proj_on}, 2'b00);
        reset = 0; t1_req = 0; a1 = 0;
        repeat (8) begin
            step();
            a1 += int'(t1_ack);
        end
        chk("abort_no_ack", a1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
